// File: rtl/decode_execute_pkg.sv
// Shared definitions for the RV32I decode/execute slice.
//   - opcode constants for the supported RV32I major opcodes
//   - alu_op_e : operation selector for alu_core
//   - imm_type_e : immediate format selector used by the decoder
//   - alu_op_from_f3 : maps func3 plus the alternate bit to an ALU op
package decode_execute_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [31:0] EBREAK_MASK  = 32'hFFF0707F;
  localparam logic [31:0] EBREAK_VALUE = 32'h00100073;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NULL,
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // alt selects SUB (func3 000) or SRA (func3 101); caller decides when it applies.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_execute_unit_alu.sv
// alu_core: 32-bit RV32I integer ALU, purely combinational.
//   a, b   : operands
//   op     : operation (alu_op_e)
//   result : a op b; shifts use b[4:0] as the shift amount
module alu_core
  import decode_execute_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result
);

  logic [4:0] w_shamt;
  assign w_shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << w_shamt;
      ALU_SLT:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: result = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> w_shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/decode_execute_unit.sv
// decode_execute_unit: single-cycle RV32I decode and execute stage.
//   clk, rst            : clock and synchronous active-high reset (flags only)
//   inst, pc            : instruction and its address
//   src1, src2          : register-file read data for rs1/rs2
//   rs1, rs2, rd        : register indices extracted from inst
//   imm                 : sign-extended immediate (0 for R / no-immediate formats)
//   opcode, func3       : raw instruction fields
//   wen                 : register write-back enable
//   mem_valid, mem_wen  : memory request and store flag; wmask byte mask
//   aluout              : ALU result, memory address or branch/jump target
//   ben, jen            : branch taken, jump
//   ebreak              : current inst is EBREAK
//   illegal_q, ebreak_q : sticky flags, cleared by rst
module decode_execute_unit
  import decode_execute_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        wen,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [7:0]  wmask,
  output logic [31:0] aluout,
  output logic        ben,
  output logic        jen,
  output logic        ebreak,
  output logic        illegal_q,
  output logic        ebreak_q
);

  imm_type_e   w_imm_type;
  logic [31:0] w_imm;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  alu_op_e     w_alu_op;
  logic [31:0] w_alu_result;
  logic        w_illegal;
  logic        w_br_cond;
  logic        w_wen_raw;
  logic        w_jen_raw;
  logic        w_memv_raw;
  logic        w_memw_raw;

  logic r_illegal_q;
  logic r_ebreak_q;

  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];
  assign opcode = inst[6:0];
  assign func3  = inst[14:12];
  assign imm    = w_imm;
  assign ebreak = ((inst & EBREAK_MASK) == EBREAK_VALUE);

  // Immediate format and legality from the major opcode.
  always_comb begin
    w_imm_type = IMM_NULL;
    w_illegal  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC:           w_imm_type = IMM_U;
      OPC_JAL:                      w_imm_type = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: w_imm_type = IMM_I;
      OPC_BRANCH:                   w_imm_type = IMM_B;
      OPC_STORE:                    w_imm_type = IMM_S;
      OPC_OP:                       w_imm_type = IMM_R;
      OPC_MISCMEM, OPC_SYSTEM:      w_imm_type = IMM_NULL;
      default:                      w_illegal  = 1'b1;
    endcase
    if (opcode == OPC_BRANCH && (func3 == 3'b010 || func3 == 3'b011))
      w_illegal = 1'b1;
    if (opcode == OPC_LOAD && (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111))
      w_illegal = 1'b1;
    if (opcode == OPC_STORE && func3 > 3'b010)
      w_illegal = 1'b1;
  end

  always_comb begin
    w_imm = '0;
    case (w_imm_type)
      IMM_I:   w_imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   w_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   w_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   w_imm = {inst[31:12], 12'b0};
      IMM_J:   w_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // Operand routing; unselected opcodes add 0 + 0 so aluout reads 0.
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        w_alu_a  = src1;
        w_alu_b  = src2;
        w_alu_op = alu_op_from_f3(func3, inst[30]);
      end
      OPC_OPIMM: begin
        w_alu_a  = src1;
        w_alu_b  = w_imm;
        // inst[30] is an immediate bit for ADDI; only SRAI uses it as a selector.
        w_alu_op = alu_op_from_f3(func3, inst[30] && func3 == 3'b101);
      end
      OPC_LUI: begin
        w_alu_b = w_imm;
      end
      OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
        w_alu_a = pc;
        w_alu_b = w_imm;
      end
      OPC_JALR, OPC_LOAD, OPC_STORE: begin
        w_alu_a = src1;
        w_alu_b = w_imm;
      end
      default: ;
    endcase
  end

  alu_core u_alu (
    .a      (w_alu_a),
    .b      (w_alu_b),
    .op     (w_alu_op),
    .result (w_alu_result)
  );

  assign aluout = (opcode == OPC_JALR) ? (w_alu_result & ~32'd1) : w_alu_result;

  always_comb begin
    w_br_cond = 1'b0;
    case (func3)
      3'b000:  w_br_cond = (src1 == src2);
      3'b001:  w_br_cond = (src1 != src2);
      3'b100:  w_br_cond = ($signed(src1) < $signed(src2));
      3'b101:  w_br_cond = ($signed(src1) >= $signed(src2));
      3'b110:  w_br_cond = (src1 < src2);
      3'b111:  w_br_cond = (src1 >= src2);
      default: w_br_cond = 1'b0;
    endcase
  end

  assign w_wen_raw  = (opcode == OPC_OP) || (opcode == OPC_OPIMM) || (opcode == OPC_LOAD) ||
                      (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                      (opcode == OPC_JALR);
  assign w_jen_raw  = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign w_memv_raw = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  assign w_memw_raw = (opcode == OPC_STORE);

  assign wen       = w_wen_raw  && !w_illegal;
  assign jen       = w_jen_raw  && !w_illegal;
  assign mem_valid = w_memv_raw && !w_illegal;
  assign mem_wen   = w_memw_raw && !w_illegal;
  assign ben       = (opcode == OPC_BRANCH) && w_br_cond && !w_illegal;

  always_comb begin
    wmask = 8'h00;
    if (opcode == OPC_STORE) begin
      case (func3)
        3'b000:  wmask = 8'h01;
        3'b001:  wmask = 8'h03;
        3'b010:  wmask = 8'h0F;
        default: wmask = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal_q <= 1'b0;
      r_ebreak_q  <= 1'b0;
    end else begin
      if (w_illegal) r_illegal_q <= 1'b1;
      if (ebreak)    r_ebreak_q  <= 1'b1;
    end
  end

  assign illegal_q = r_illegal_q;
  assign ebreak_q  = r_ebreak_q;

endmodule

// File: tb/tb_decode_execute_unit.sv
module tb_decode_execute_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, pc, src1, src2;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, aluout;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        wen, mem_valid, mem_wen, ben, jen, ebreak, illegal_q, ebreak_q;
  logic [7:0]  wmask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_execute_unit dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .src1(src1), .src2(src2),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .opcode(opcode), .func3(func3),
    .wen(wen), .mem_valid(mem_valid), .mem_wen(mem_wen), .wmask(wmask),
    .aluout(aluout), .ben(ben), .jen(jen), .ebreak(ebreak),
    .illegal_q(illegal_q), .ebreak_q(ebreak_q)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] alu;
    logic        wen, memv, memw;
    logic [7:0]  wmask;
    logic        ben, jen, ebreak, illegal;
  } exp_t;

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, input logic alt);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: return (a < b) ? 1 : 0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt && a[31]) return ~((~a) >> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Reference behaviour straight from the RV32I rules, one opcode at a time.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0] f3;
    logic [31:0] ii, is, ib, iu, ij;
    e  = '0;
    f3 = i[14:12];
    ii = {{20{i[31]}}, i[31:20]};
    is = {{20{i[31]}}, i[31:25], i[11:7]};
    ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    iu = {i[31:12], 12'b0};
    ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      7'b0110111: begin e.imm = iu; e.alu = iu; e.wen = 1; end
      7'b0010111: begin e.imm = iu; e.alu = p + iu; e.wen = 1; end
      7'b1101111: begin e.imm = ij; e.alu = p + ij; e.wen = 1; e.jen = 1; end
      7'b1100111: begin e.imm = ii; e.alu = (a + ii) & 32'hFFFFFFFE; e.wen = 1; e.jen = 1; end
      7'b1100011: begin
        e.imm = ib; e.alu = p + ib;
        case (f3)
          3'd0: e.ben = (a == b);
          3'd1: e.ben = (a != b);
          3'd4: e.ben = ($signed(a) < $signed(b));
          3'd5: e.ben = !($signed(a) < $signed(b));
          3'd6: e.ben = (a < b);
          3'd7: e.ben = !(a < b);
          default: e.illegal = 1;
        endcase
      end
      7'b0000011: begin
        e.imm = ii; e.alu = a + ii; e.wen = 1; e.memv = 1;
        e.illegal = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'b0100011: begin
        e.imm = is; e.alu = a + is; e.memv = 1; e.memw = 1;
        e.wmask = (f3 == 0) ? 8'h01 : (f3 == 1) ? 8'h03 : (f3 == 2) ? 8'h0F : 8'h00;
        e.illegal = (f3 > 2);
      end
      7'b0010011: begin
        e.imm = ii; e.wen = 1;
        e.alu = ref_alu(f3, a, ii, f3 == 5 && i[30]);
      end
      7'b0110011: begin
        e.wen = 1;
        e.alu = ref_alu(f3, a, b, i[30]);
      end
      7'b0001111, 7'b1110011: ;
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin
      e.wen = 0; e.memv = 0; e.memw = 0; e.ben = 0; e.jen = 0;
    end
    e.ebreak = ((i & 32'hFFF0707F) == 32'h00100073);
    return e;
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    inst = i; pc = p; src1 = a; src2 = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h00000013, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    total++;
    if ({illegal_q, ebreak_q} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got=%b want=00", {illegal_q, ebreak_q});
    end
    // Combinational path still works while rst is held.
    drive(32'h00500093, 32'h0, 32'h0, 32'h0);
    total++;
    if ({aluout, wen} !== {32'd5, 1'b1}) begin
      bad++; $display("FAIL reset_comb got alu=%h wen=%b want alu=5 wen=1", aluout, wen);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    drive(32'h00500093, 32'h0, 32'h0, 32'h0);
    total++;
    if ({rd, imm, aluout, wen, mem_valid} !== {5'd1, 32'd5, 32'd5, 1'b1, 1'b0}) begin
      bad++; $display("FAIL addi got rd=%0d imm=%h alu=%h wen=%b mv=%b want 1/5/5/1/0",
                      rd, imm, aluout, wen, mem_valid);
    end
    drive(32'h40208133, 32'h0, 32'd3, 32'd5);
    total++;
    if ({aluout, wen} !== {32'hFFFFFFFE, 1'b1}) begin
      bad++; $display("FAIL sub got alu=%h wen=%b want fffffffe/1", aluout, wen);
    end
    drive(32'hFE208EE3, 32'h80000010, 32'd7, 32'd7);
    total++;
    if ({imm, aluout, ben} !== {32'hFFFFFFFC, 32'h8000000C, 1'b1}) begin
      bad++; $display("FAIL beq_taken got imm=%h alu=%h ben=%b want fffffffc/8000000c/1",
                      imm, aluout, ben);
    end
    drive(32'hFE208EE3, 32'h80000010, 32'd7, 32'd8);
    total++;
    if (ben !== 1'b0) begin
      bad++; $display("FAIL beq_not_taken got ben=%b want 0", ben);
    end
    drive(32'h00A12423, 32'h0, 32'h80001000, 32'h0);
    total++;
    if ({aluout, mem_valid, mem_wen, wmask, wen} !== {32'h80001008, 1'b1, 1'b1, 8'h0F, 1'b0}) begin
      bad++; $display("FAIL sw got alu=%h mv=%b mw=%b mask=%h wen=%b want 80001008/1/1/0f/0",
                      aluout, mem_valid, mem_wen, wmask, wen);
    end
    drive(32'h004080E7, 32'h0, 32'h80000101, 32'h0);
    total++;
    if ({aluout, jen, wen} !== {32'h80000104, 1'b1, 1'b1}) begin
      bad++; $display("FAIL jalr got alu=%h jen=%b wen=%b want 80000104/1/1", aluout, jen, wen);
    end
    // ADDI with inst[30] set (imm = 0x400) must still add.
    drive(32'h40008093, 32'h0, 32'd1, 32'h0);
    total++;
    if (aluout !== 32'h00000401) begin
      bad++; $display("FAIL addi_bit30 got alu=%h want 00000401", aluout);
    end
    // SRAI x1,x1,4 on a negative value.
    drive(32'h4040D093, 32'h0, 32'h80000000, 32'h0);
    total++;
    if (aluout !== 32'hF8000000) begin
      bad++; $display("FAIL srai got alu=%h want f8000000", aluout);
    end
  endtask

  task automatic test_flags();
    drive(32'h00100073, 32'h0, 32'h0, 32'h0);
    total++;
    if (ebreak !== 1'b1) begin
      bad++; $display("FAIL ebreak_comb got %b want 1", ebreak);
    end
    @(posedge clk); #1;
    total++;
    if ({ebreak_q, illegal_q} !== 2'b10) begin
      bad++; $display("FAIL ebreak_q got eq=%b iq=%b want 1/0", ebreak_q, illegal_q);
    end
    drive(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    total++;
    if (wen !== 1'b0) begin
      bad++; $display("FAIL illegal_wen got %b want 0", wen);
    end
    @(posedge clk); #1;
    total++;
    if ({ebreak_q, illegal_q} !== 2'b11) begin
      bad++; $display("FAIL illegal_q got eq=%b iq=%b want 1/1", ebreak_q, illegal_q);
    end
    drive(32'h00000013, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    total++;
    if ({ebreak_q, illegal_q} !== 2'b11) begin
      bad++; $display("FAIL sticky got eq=%b iq=%b want 1/1", ebreak_q, illegal_q);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ebreak_q, illegal_q} !== 2'b00) begin
      bad++; $display("FAIL flag_clear got eq=%b iq=%b want 0/0", ebreak_q, illegal_q);
    end
    // rst wins over coincident set conditions.
    drive(32'h00100073, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    total++;
    if ({ebreak_q, illegal_q} !== 2'b00) begin
      bad++; $display("FAIL rst_priority got eq=%b iq=%b want 0/0", ebreak_q, illegal_q);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] opcs [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                              7'b1110011};
    logic [31:0] i, p, a, b;
    exp_t e;
    logic exp_iq, exp_eq;
    exp_iq = 0; exp_eq = 0;
    for (int n = 0; n < 400; n++) begin
      if (n % 40 == 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_iq = 0; exp_eq = 0;
      end
      i = $urandom;
      case ($urandom_range(0, 15))
        0, 1:    ;
        2:       i = (i & ~32'hFFF0707F) | 32'h00100073;
        default: i[6:0] = opcs[$urandom_range(0, 10)];
      endcase
      p = $urandom;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      e = model(i, p, a, b);
      drive(i, p, a, b);
      total++;
      if ({rs1, rs2, rd, opcode, func3} !== {i[19:15], i[24:20], i[11:7], i[6:0], i[14:12]}) begin
        bad++; $display("FAIL rnd_fields inst=%h got rs1=%0d rs2=%0d rd=%0d op=%b f3=%b",
                        i, rs1, rs2, rd, opcode, func3);
      end
      total++;
      if ({imm, aluout, wen, mem_valid, mem_wen, wmask, ben, jen, ebreak} !==
          {e.imm, e.alu, e.wen, e.memv, e.memw, e.wmask, e.ben, e.jen, e.ebreak}) begin
        bad++;
        $display("FAIL rnd_exec inst=%h pc=%h s1=%h s2=%h got imm=%h alu=%h wen=%b mv=%b mw=%b mask=%h ben=%b jen=%b eb=%b want imm=%h alu=%h wen=%b mv=%b mw=%b mask=%h ben=%b jen=%b eb=%b",
                 i, p, a, b, imm, aluout, wen, mem_valid, mem_wen, wmask, ben, jen, ebreak,
                 e.imm, e.alu, e.wen, e.memv, e.memw, e.wmask, e.ben, e.jen, e.ebreak);
      end
      @(posedge clk); #1;
      exp_iq = exp_iq | e.illegal;
      exp_eq = exp_eq | e.ebreak;
      total++;
      if ({illegal_q, ebreak_q} !== {exp_iq, exp_eq}) begin
        bad++; $display("FAIL rnd_flags inst=%h got iq=%b eq=%b want iq=%b eq=%b",
                        i, illegal_q, ebreak_q, exp_iq, exp_eq);
      end
    end
  endtask

  initial begin
    rst = 1'b1; inst = '0; pc = '0; src1 = '0; src2 = '0;
    test_reset();
    test_directed();
    test_flags();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_execute_unit.md
DECODE_EXECUTE_UNIT -- requirements
Module: decode_execute_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed (XLEN 32, register index 5).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port inst, input, 32 bits: current RV32I instruction.
REQ-005 SHALL have port pc, input, 32 bits: address of inst.
REQ-006 SHALL have ports src1 and src2, input, 32 bits each: register-file read data for rs1 and rs2.
REQ-007 SHALL have ports rs1, rs2 and rd, output, 5 bits each: inst[19:15], inst[24:20] and inst[11:7], always driven.
REQ-008 SHALL have port imm, output, 32 bits: sign-extended immediate.
REQ-009 SHALL have ports opcode (output, 7 bits, inst[6:0]) and func3 (output, 3 bits, inst[14:12]).
REQ-010 SHALL have port wen, output, 1 bit: register write-back enable.
REQ-011 SHALL have ports mem_valid, mem_wen (output, 1 bit each) and wmask (output, 8 bits): memory access request, store flag and byte mask.
REQ-012 SHALL have port aluout, output, 32 bits: result, memory address or branch/jump target.
REQ-013 SHALL have ports ben and jen, output, 1 bit each: branch taken and jump.
REQ-014 SHALL have ports ebreak, illegal_q and ebreak_q, output, 1 bit each.

Function
REQ-015 SHALL compute all outputs except illegal_q and ebreak_q combinationally from inst, pc, src1 and src2 with zero latency.
REQ-016 SHALL decode immediates by type:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - I, S, B and J are sign-extended; R and unsupported formats give imm = 0.
REQ-017 SHALL form aluout per instruction:
  - OP: src1 op src2
  - OP-IMM: src1 op imm
  - LUI: imm
  - AUIPC, JAL and branches: pc+imm
  - JALR: (src1+imm) & ~1
  - loads and stores: src1+imm
  - anything else: 0
REQ-018 SHALL implement ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND:
  - shift amount is the low 5 bits of the operand;
  - SUB and SRA are selected by inst[30] only for OP, and for OP-IMM shifts (SRAI);
  - ADDI with inst[30] set remains an add.
REQ-019 SHALL assert wen for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, including when rd = 0 (x0 writes are discarded by the register file).
REQ-020 SHALL assert jen for JAL (1101111) and JALR (1100111).
REQ-021 SHALL assert ben only for opcode 1100011, comparing src1 with src2:
  - BEQ (000): equal
  - BNE (001): not equal
  - BLT (100): signed less-than
  - BGE (101): signed greater-or-equal
  - BLTU (110): unsigned less-than
  - BGEU (111): unsigned greater-or-equal
  - func3 010 and 011 give ben = 0.
REQ-022 SHALL assert mem_valid for LOAD (0000011) and STORE (0100011), and mem_wen for STORE only.
REQ-023 SHALL drive wmask for stores as SB 0x01, SH 0x03, SW 0x0F, and 0x00 for all non-store instructions.
REQ-024 SHALL drive ebreak = 1 exactly when (inst & 0xFFF0707F) == 0x00100073.
REQ-025 SHALL treat all of the following as illegal (combinational internal flag):
  - opcodes outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM};
  - branch func3 010 or 011;
  - load func3 011, 110 or 111;
  - store func3 above 010.
  Illegal instructions SHALL have wen, mem_valid, mem_wen, ben and jen all forced to 0.
REQ-026 SHALL treat MISC-MEM (FENCE) and non-ebreak SYSTEM instructions as legal no-ops, with all enables at 0.
REQ-027 SHALL set illegal_q on a rising edge when the current inst is illegal, and hold it (sticky) until reset.
REQ-028 SHALL set ebreak_q on a rising edge when ebreak = 1, and hold it (sticky) until reset.
REQ-029 SHALL give rst priority on a rising edge where rst and a set condition coincide: the flag clears.

Reset
REQ-030 SHALL clear illegal_q and ebreak_q to 0 on a rising edge with rst = 1.
REQ-031 SHALL keep combinational outputs functional during reset; they do not depend on rst.

Structure
REQ-032 SHALL place opcode constants, the ALU-op enum and the immediate-type enum (NULL, R, I, S, B, U, J) in a shared package, decode_execute_pkg.
REQ-033 SHALL implement the arithmetic in one sub-module, alu_core (operands a and b, op, result); decode, branch compare and flags stay in the top module.

Verification
REQ-034 SHALL cover this scenario: inst 0x00500093 (ADDI x1,x0,5), src1 = 0 -> rd = 1, imm = 5, aluout = 5, wen = 1, mem_valid = 0.
REQ-035 SHALL cover this scenario: inst 0x40208133 (SUB x2,x1,x2), src1 = 3, src2 = 5 -> aluout = 0xFFFFFFFE, wen = 1.
REQ-036 SHALL cover this scenario: inst 0xFE208EE3 (BEQ x1,x2,-4), pc = 0x80000010, src1 = src2 = 7 -> imm = 0xFFFFFFFC, aluout = 0x8000000C, ben = 1; with src2 = 8 -> ben = 0.
REQ-037 SHALL cover this scenario: inst 0x00A12423 (SW x10,8(x2)), src1 = 0x80001000 -> aluout = 0x80001008, mem_valid = 1, mem_wen = 1, wmask = 0x0F, wen = 0.
REQ-038 SHALL cover this scenario: inst 0x004080E7 (JALR x1,4(x1)), src1 = 0x80000101 -> aluout = 0x80000104, jen = 1, wen = 1.
REQ-039 SHALL cover this scenario: inst 0x00100073, clock -> ebreak = 1, then ebreak_q = 1; inst 0xFFFFFFFF, clock -> illegal_q = 1, wen = 0; rst = 1, clock -> both flags 0.
